// File: rtl/reg_select_pkg.sv
// Shared types and constants for the register-select decoder.
package reg_select_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

endpackage

// File: rtl/reg_select_decoder_bin2onehot.sv
// Combinational binary index to one-hot converter.
module bin2onehot #(
    parameter int ADDR_W = 5,
    localparam int OUT_W = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0] idx_i,
    output logic [OUT_W-1:0]  onehot_o
);

    assign onehot_o = OUT_W'(1) << idx_i;

endmodule

// File: rtl/reg_select_decoder.sv
// One-hot register-select decoder with single-shot and sweep modes.
// Optional macro REG_SELECT_ZERO_PROTECT_EN keeps output bit 0 permanently low.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for a request; a DIRECT select may be presented
//   SWEEP | walking the one-hot select from the start index up to the top
module reg_select_decoder
    import reg_select_pkg::*;
#(
    parameter int ADDR_W = 5,
    localparam int OUT_W = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic              abort,
    output logic [OUT_W-1:0]  y,
    output logic              y_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [OUT_W-1:0]  BIT0     = OUT_W'(1);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [ADDR_W-1:0] start_idx;
    logic [ADDR_W-1:0] sel_idx;
    logic [OUT_W-1:0]  onehot;
    logic [OUT_W-1:0]  y_sel;
    logic [OUT_W-1:0]  y_q;
    logic              y_valid_q;
    logic              done_q;

    assign cnt_d = cnt_q + 1'b1;

`ifdef REG_SELECT_ZERO_PROTECT_EN
    // A sweep never visits index 0; a DIRECT hit on 0 is masked below instead.
    assign start_idx = (mode == MODE_SWEEP && addr == '0) ? ADDR_W'(1) : addr;
    assign y_sel     = onehot & ~BIT0;
`else
    assign start_idx = addr;
    assign y_sel     = onehot;
`endif

    // The select register always captures the index that will be on y next cycle.
    assign sel_idx = (state_q == SWEEP) ? cnt_d : start_idx;

    bin2onehot #(.ADDR_W(ADDR_W)) u_bin2onehot (
        .idx_i    (sel_idx),
        .onehot_o (onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        y_q       <= y_sel;
                        y_valid_q <= 1'b1;
                        if (mode == MODE_SWEEP) begin
                            state_q <= SWEEP;
                            cnt_q   <= start_idx;
                            done_q  <= (start_idx == LAST_IDX);
                        end
                    end
                end
                SWEEP: begin
                    if (abort || cnt_q == LAST_IDX) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q     <= cnt_d;
                        y_q       <= y_sel;
                        y_valid_q <= 1'b1;
                        done_q    <= (cnt_d == LAST_IDX);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == SWEEP);
    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign done     = done_q;

endmodule

// File: tb/tb_reg_select_decoder.sv
// Self-checking bench: queue-based reference model plus directed and random stimulus.
module tb_reg_select_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [4:0]  addr;
    logic        abort;
    logic [31:0] y;
    logic        y_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    reg_select_decoder #(.ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .addr     (addr),
        .abort    (abort),
        .y        (y),
        .y_valid  (y_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference: each cycle's expected outputs, queued up when a request is accepted.
    typedef struct packed {
        logic [31:0] y;
        logic        v;
        logic        busy;
        logic        done;
    } ent_t;

    ent_t q[$];
    ent_t cur = '0;

    always @(posedge clk) begin
        int          s;
        logic [31:0] yv;
        if (!rst_n) begin
            q.delete();
            cur = '0;
        end else if (cur.busy && abort) begin
            q.delete();
            cur = '0;
        end else begin
            if (!cur.busy && in_valid) begin
                if (mode) begin
                    s = int'(addr);
`ifdef REG_SELECT_ZERO_PROTECT_EN
                    if (s == 0) s = 1;
`endif
                    for (int i = s; i < 32; i++)
                        q.push_back(ent_t'{y: 32'd1 << i, v: 1'b1, busy: 1'b1, done: (i == 31)});
                end else begin
                    yv = 32'd1 << addr;
`ifdef REG_SELECT_ZERO_PROTECT_EN
                    yv[0] = 1'b0;
`endif
                    q.push_back(ent_t'{y: yv, v: 1'b1, busy: 1'b0, done: 1'b0});
                end
            end
            cur = (q.size() > 0) ? q.pop_front() : ent_t'('0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_y", y, cur.y);
            chk("model_y_valid", 32'(y_valid), 32'(cur.v));
            chk("model_busy", 32'(busy), 32'(cur.busy));
            chk("model_done", 32'(done), 32'(cur.done));
            chk("model_in_ready", 32'(in_ready), 32'(!cur.busy));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic [4:0] a, input logic ab);
        in_valid = v;
        mode     = m;
        addr     = a;
        abort    = ab;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        tick();
        cmp_en = 1'b1;
        chk("rst_y", y, 32'h0);
        chk("rst_valid_busy_done", {29'd0, y_valid, busy, done}, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;
        tick();

        // Single DIRECT select to index 5
        drive(1, 0, 5'd5, 0);
        tick();
        drive(0, 0, 0, 0);
        chk("direct5_y", y, 32'h0000_0020);
        chk("direct5_valid", 32'(y_valid), 32'h1);
        tick();
        chk("direct5_after_y", y, 32'h0);
        chk("direct5_after_valid", 32'(y_valid), 32'h0);

        // Short sweep from 28 to the top
        drive(1, 1, 5'd28, 0);
        tick();
        drive(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("sweep28_y", y, 32'h1000_0000 << k);
            chk("sweep28_done", 32'(done), 32'(k == 3));
            chk("sweep28_busy", 32'(busy), 32'h1);
            tick();
        end
        chk("sweep28_ready_after", 32'(in_ready), 32'h1);
        chk("sweep28_busy_after", 32'(busy), 32'h0);

        // Sweep from 10 aborted while presenting 12; DIRECT 7 requests ignored meanwhile
        drive(1, 1, 5'd10, 0);
        tick();
        drive(1, 0, 5'd7, 0);
        chk("abort_y10", y, 32'h0000_0400);
        tick();
        chk("abort_y11", y, 32'h0000_0800);
        tick();
        chk("abort_y12", y, 32'h0000_1000);
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        chk("abort_y", y, 32'h0);
        chk("abort_valid_busy_done", {29'd0, y_valid, busy, done}, 32'h0);

        // Reset mid-sweep at index 20
        drive(1, 1, 5'd17, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        tick();
        tick();
        chk("rstsw_y20", y, 32'h0010_0000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstsw_y", y, 32'h0);
        chk("rstsw_valid_busy_done", {29'd0, y_valid, busy, done}, 32'h0);
        chk("rstsw_in_ready", 32'(in_ready), 32'h1);
        drive(1, 0, 5'd3, 0);
        tick();
        drive(0, 0, 0, 0);
        chk("rstsw_direct3", y, 32'h0000_0008);

        // Index 0 handling
        drive(1, 0, 5'd0, 0);
        tick();
        drive(0, 0, 0, 0);
`ifdef REG_SELECT_ZERO_PROTECT_EN
        chk("zero_direct_y", y, 32'h0);
        chk("zero_direct_valid", 32'(y_valid), 32'h1);
        tick();
        drive(1, 1, 5'd0, 0);
        tick();
        drive(0, 0, 0, 0);
        chk("zero_sweep_first", y, 32'h0000_0002);
        n = 0;
        for (int k = 0; k < 40 && y_valid; k++) begin
            n++;
            tick();
        end
        chk("zero_sweep_len", 32'(n), 32'd31);
`else
        chk("zero_direct_y", y, 32'h0000_0001);
        chk("zero_direct_valid", 32'(y_valid), 32'h1);
`endif
        tick();

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            in_valid = ($urandom_range(0, 1) == 1);
            mode     = ($urandom_range(0, 9) < 3);
            addr     = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(24, 31))
                                                   : 5'($urandom_range(0, 31));
            abort    = ($urandom_range(0, 19) == 0);
            tick();
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_select_decoder.md
REG_SELECT_DECODER -- requirements
Module: reg_select_decoder

Interface
REQ-001 Parameter ADDR_W, default 5, is the binary select width; OUT_W = 2**ADDR_W is derived internally and SHALL NOT be overridable.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 mode  input  1  0 = DIRECT (single decode), 1 = SWEEP (walk outputs).
REQ-007 addr  input  ADDR_W  DIRECT target index, or SWEEP start index.
REQ-008 abort  input  1  terminates an active sweep.
REQ-009 y  output  OUT_W  registered one-hot select, or all-zero.
REQ-010 y_valid  output  1  y carries a select this cycle.
REQ-011 busy  output  1  sweep in progress.
REQ-012 done  output  1  one-cycle pulse on the final sweep select.

Function
REQ-013 The block SHALL use two states, IDLE and SWEEP; in_ready SHALL be 1 exactly when state is IDLE.
REQ-014 A request SHALL be accepted when in_valid and in_ready are both 1; in_valid with in_ready=0 SHALL be ignored and not queued.
REQ-015 DIRECT accept: the next cycle SHALL present y = 1<<addr, y_valid=1 for exactly one cycle, and the state SHALL remain IDLE (latency 1, back-to-back accepts allowed).
REQ-016 SWEEP accept: the state SHALL become SWEEP and an index counter SHALL load addr; y = 1<<addr and y_valid=1 SHALL appear the next cycle.
REQ-017 In SWEEP, the counter SHALL increment by 1 per cycle, with y one-hot at the counter and y_valid=1 every cycle, through index OUT_W-1 inclusive.
REQ-018 The cycle presenting index OUT_W-1 SHALL assert done=1; the state SHALL return to IDLE on the following edge; the counter SHALL NOT wrap.
REQ-019 A sweep started at addr=OUT_W-1 SHALL last one cycle, with y_valid and done both asserted.
REQ-020 busy SHALL be 1 exactly while state is SWEEP.
REQ-021 abort=1 in SWEEP SHALL force IDLE on the next edge, with y=0 and y_valid=0 that cycle; abort SHALL take priority over the last index, so done stays 0; abort in IDLE SHALL have no effect.
REQ-022 When no select is presented, y SHALL be all-zero and y_valid 0; y SHALL never be X or multi-hot.

Reset
REQ-023 rst_n=0 at a clock edge SHALL set state IDLE, counter 0, y=0, y_valid=0, busy=0, done=0; in_ready SHALL then read 1.
REQ-024 Reset mid-sweep SHALL abandon the sweep without a done pulse.

Configuration
REQ-025 Macro REG_SELECT_ZERO_PROTECT_EN defined: output bit 0 SHALL never assert. A DIRECT request to addr 0 SHALL give y=0 with y_valid=1. A sweep starting at 0 SHALL begin at index 1.
REQ-026 Macro REG_SELECT_ZERO_PROTECT_EN undefined: index 0 SHALL decode like any other index.

Structure
REQ-027 Shared package reg_select_pkg SHALL hold the state enum typedef (IDLE, SWEEP) and the mode constants MODE_DIRECT=0 and MODE_SWEEP=1.
REQ-028 One combinational sub-module, bin2onehot (parameter ADDR_W), SHALL perform index-to-one-hot conversion; it SHALL be instantiated once and fed by a mux of addr and the counter.

Verification (ADDR_W=5)
REQ-029 DIRECT addr=5 -> next cycle y=0x00000020, y_valid=1; following cycle y=0, y_valid=0.
REQ-030 SWEEP addr=28 -> y=0x10000000, 0x20000000, 0x40000000, 0x80000000 on 4 consecutive cycles; done only with 0x80000000; busy=1 for those 4 cycles; in_ready=1 the cycle after.
REQ-031 SWEEP addr=10, abort on the 3rd select cycle (index 12) -> next cycle y=0, y_valid=0, busy=0, done never 1.
REQ-032 rst_n=0 during a sweep at index 20 -> next cycle all outputs 0, in_ready=1; a DIRECT addr=3 afterwards gives y=0x00000008.
REQ-033 With REG_SELECT_ZERO_PROTECT_EN: DIRECT addr=0 -> y=0, y_valid=1; SWEEP addr=0 -> first y=0x00000002, 31 select cycles. Without the macro: DIRECT addr=0 -> y=0x00000001.
REQ-034 Request in SWEEP (in_valid=1, mode=0, addr=7) -> ignored; y never equals 0x00000080 out of order.
